// File: rtl/palette_loader.sv
// Bus master that loads a block of CGB palette bytes into the colour file via BCPS/BCPD or OCPS/OCPD.
// Optional build macro PALLOAD_CHECKSUM_EN adds O_CHECKSUM, the mod-256 sum of the bytes written.
module palette_loader #(
  parameter logic [15:0] BCPS_ADDR = 16'hFF68,
  parameter logic [15:0] BCPD_ADDR = 16'hFF69,
  parameter logic [15:0] OCPS_ADDR = 16'hFF6A,
  parameter logic [15:0] OCPD_ADDR = 16'hFF6B
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_START,
  input  logic        I_TARGET_OBJ,
  input  logic [5:0]  I_START_INDEX,
  input  logic [15:0] I_SRC_ADDR,
  input  logic [6:0]  I_COUNT,
  output logic        O_BUS_REQ,
  input  logic        I_BUS_GNT,
  output logic        O_RD_EN,
  output logic [15:0] O_RD_ADDR,
  input  logic [7:0]  I_RD_DATA,
  output logic [15:0] O_MEMBUS_ADDR,
  output logic [7:0]  O_DATA,
  output logic        O_MEMBUS_WE_L,
  output logic        O_BUSY,
  output logic        O_DONE
`ifdef PALLOAD_CHECKSUM_EN
  ,
  output logic [7:0]  O_CHECKSUM
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SPEC,
    S_RD,
    S_WR,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        obj_q, obj_d;
  logic [5:0]  index_q, index_d;
  logic [15:0] src_q, src_d;
  logic [6:0]  remaining_q, remaining_d;

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A write cycle without grant falls back to RD so the same source byte is fetched again.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (I_START) begin
          state_d = (I_COUNT == 7'd0) ? S_DONE : S_REQ;
        end
      end
      S_REQ:  if (I_BUS_GNT) state_d = S_SPEC;
      S_SPEC: if (I_BUS_GNT) state_d = S_RD;
      S_RD:   if (I_BUS_GNT) state_d = S_WR;
      S_WR: begin
        if (!I_BUS_GNT) begin
          state_d = S_RD;
        end else if (remaining_q == 7'd1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    O_BUS_REQ     = 1'b0;
    O_RD_EN       = 1'b0;
    O_RD_ADDR     = 16'h0000;
    O_MEMBUS_ADDR = 16'h0000;
    O_DATA        = 8'h00;
    O_MEMBUS_WE_L = 1'b1;
    O_BUSY        = (state_q != S_IDLE);
    O_DONE        = 1'b0;
    case (state_q)
      S_REQ: O_BUS_REQ = 1'b1;
      S_SPEC: begin
        O_BUS_REQ = 1'b1;
        if (I_BUS_GNT) begin
          O_MEMBUS_ADDR = obj_q ? OCPS_ADDR : BCPS_ADDR;
          O_DATA        = {1'b1, 1'b0, index_q};
          O_MEMBUS_WE_L = 1'b0;
        end
      end
      S_RD: begin
        O_BUS_REQ = 1'b1;
        if (I_BUS_GNT) begin
          O_RD_EN   = 1'b1;
          O_RD_ADDR = src_q;
        end
      end
      S_WR: begin
        O_BUS_REQ = 1'b1;
        if (I_BUS_GNT) begin
          O_MEMBUS_ADDR = obj_q ? OCPD_ADDR : BCPD_ADDR;
          O_DATA        = I_RD_DATA;
          O_MEMBUS_WE_L = 1'b0;
        end
      end
      S_DONE:  O_DONE = 1'b1;
      default: ;
    endcase
  end

  wire startAccept = (state_q == S_IDLE) && I_START;
  wire byteWritten = (state_q == S_WR) && I_BUS_GNT;

  always_comb begin
    obj_d       = obj_q;
    index_d     = index_q;
    src_d       = src_q;
    remaining_d = remaining_q;
    if (startAccept) begin
      obj_d       = I_TARGET_OBJ;
      index_d     = I_START_INDEX;
      src_d       = I_SRC_ADDR;
      remaining_d = I_COUNT;
    end else if (byteWritten) begin
      src_d       = src_q + 16'd1;
      remaining_d = remaining_q - 7'd1;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      obj_q       <= 1'b0;
      index_q     <= 6'd0;
      src_q       <= 16'h0000;
      remaining_q <= 7'd0;
    end else begin
      obj_q       <= obj_d;
      index_q     <= index_d;
      src_q       <= src_d;
      remaining_q <= remaining_d;
    end
  end

`ifdef PALLOAD_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (startAccept) begin
      checksum_d = 8'h00;
    end else if (byteWritten) begin
      checksum_d = checksum_q + I_RD_DATA;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      checksum_q <= 8'h00;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign O_CHECKSUM = checksum_q;
`endif

endmodule

// File: tb/tb_palette_loader.sv
// Self-checking bench for palette_loader: table of transfers plus reset-abort and checksum sequences.
module tb_palette_loader;

  typedef struct {
    logic        obj;
    logic [5:0]  idx;
    logic [15:0] src;
    logic [6:0]  cnt;
    int          dropAt;
    int          dropLen;
    int          pokeAt;
    int          doneCyc;
  } vecT;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wrT;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        targetObj;
  logic [5:0]  startIndex;
  logic [15:0] srcAddr;
  logic [6:0]  count;
  logic        busReq;
  logic        busGnt;
  logic        rdEn;
  logic [15:0] rdAddr;
  logic [7:0]  rdData;
  logic [15:0] membusAddr;
  logic [7:0]  dataOut;
  logic        weL;
  logic        busy;
  logic        done;
`ifdef PALLOAD_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int total = 0;
  int bad = 0;
  wrT expQ[$];
  logic [7:0] mem [65536];
  logic        rdPend = 1'b0;
  logic [15:0] rdAddrS = 16'h0000;
  int wrIdx = 0;

  palette_loader dut (
    .I_CLK(clk),
    .I_RESET(reset),
    .I_START(start),
    .I_TARGET_OBJ(targetObj),
    .I_START_INDEX(startIndex),
    .I_SRC_ADDR(srcAddr),
    .I_COUNT(count),
    .O_BUS_REQ(busReq),
    .I_BUS_GNT(busGnt),
    .O_RD_EN(rdEn),
    .O_RD_ADDR(rdAddr),
    .I_RD_DATA(rdData),
    .O_MEMBUS_ADDR(membusAddr),
    .O_DATA(dataOut),
    .O_MEMBUS_WE_L(weL),
    .O_BUSY(busy),
    .O_DONE(done)
`ifdef PALLOAD_CHECKSUM_EN
    ,
    .O_CHECKSUM(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Source memory answers one cycle after a read strobe.
  always @(negedge clk) begin
    rdPend  = rdEn;
    rdAddrS = rdAddr;
  end

  always @(posedge clk) begin
    #1;
    if (rdPend) rdData = mem[rdAddrS];
  end

  // Every colour-file write is matched against the scoreboard in order.
  always @(negedge clk) begin
    if (!reset && weL == 1'b0) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL write_unexpected: got addr=%h data=%h want no write", membusAddr, dataOut);
      end else begin
        wrT e;
        e = expQ.pop_front();
        if (membusAddr !== e.addr || dataOut !== e.data) begin
          bad++;
          $display("[TB] FAIL write[%0d]: got addr=%h data=%h want addr=%h data=%h",
                   wrIdx, membusAddr, dataOut, e.addr, e.data);
        end
      end
      wrIdx++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 'h%0h want 'h%0h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_bus_req"}, 32'(busReq), 32'd0);
    checkOutput({tag, "_rd_en"}, 32'(rdEn), 32'd0);
    checkOutput({tag, "_rd_addr"}, 32'(rdAddr), 32'd0);
    checkOutput({tag, "_membus_addr"}, 32'(membusAddr), 32'd0);
    checkOutput({tag, "_data"}, 32'(dataOut), 32'd0);
    checkOutput({tag, "_we_l"}, 32'(weL), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
`ifdef PALLOAD_CHECKSUM_EN
    checkOutput({tag, "_checksum"}, 32'(checksum), 32'd0);
`endif
  endtask

  // Drives one transfer, pushes its expected writes and checks done timing and bus request.
  task automatic applyStimulus(input vecT v, input string name);
    int k;
    int doneCyc;
    bit finished;
    bit reqSeen;
    logic [7:0] sum;
    k = 1;
    doneCyc = -1;
    finished = 0;
    reqSeen = 0;
    sum = 8'h00;
    if (v.cnt != 7'd0) begin
      expQ.push_back('{addr: v.obj ? 16'hFF6A : 16'hFF68, data: {2'b10, v.idx}});
      for (int i = 0; i < int'(v.cnt); i++) begin
        logic [15:0] a;
        a = v.src + 16'(i);
        expQ.push_back('{addr: v.obj ? 16'hFF6B : 16'hFF69, data: mem[a]});
        sum = sum + mem[a];
      end
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    targetObj = v.obj;
    startIndex = v.idx;
    srcAddr = v.src;
    count = v.cnt;
    busGnt = 1'b1;
    @(posedge clk);
    #1;
    while (!finished && k <= 300) begin
      busGnt = !(v.dropLen > 0 && k >= v.dropAt && k < v.dropAt + v.dropLen);
      if (k == v.pokeAt) begin
        start = 1'b1;
        targetObj = ~v.obj;
        startIndex = 6'h2A;
        srcAddr = 16'h9999;
        count = 7'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busReq) reqSeen = 1;
      if (done) begin
        doneCyc = k;
        finished = 1;
      end
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    busGnt = 1'b1;
    checkOutput({name, "_done_cycle"}, 32'(doneCyc), 32'(v.doneCyc));
    checkOutput({name, "_bus_req_seen"}, 32'(reqSeen), 32'(v.cnt != 7'd0));
    checkOutput({name, "_pending_writes"}, 32'(expQ.size()), 32'd0);
    checkOutput({name, "_idle_after"}, 32'(busy), 32'd0);
`ifdef PALLOAD_CHECKSUM_EN
    checkOutput({name, "_checksum"}, 32'(checksum), 32'(sum));
`endif
    expQ.delete();
  endtask

  vecT vecs[7];

  initial begin
    vecT v;
    bit doneSeen;
    vecs[0] = '{1'b0, 6'h00, 16'hC000, 7'd8, 0, 0, 0, 19};
    vecs[1] = '{1'b1, 6'h3E, 16'hC000, 7'd4, 0, 0, 0, 11};
    vecs[2] = '{1'b0, 6'h05, 16'h1234, 7'd0, 0, 0, 0, 1};
    vecs[3] = '{1'b0, 6'h10, 16'h4000, 7'd4, 6, 3, 0, 15};
    vecs[4] = '{1'b1, 6'h00, 16'hFFFE, 7'd3, 0, 0, 0, 9};
    vecs[5] = '{1'b0, 6'h3F, 16'h8000, 7'd2, 0, 0, 3, 7};
    vecs[6] = '{1'b1, 6'h01, 16'h2000, 7'd64, 0, 0, 0, 131};

    for (int i = 0; i < 65536; i++) begin
      logic [15:0] a;
      a = 16'(i);
      mem[i] = a[7:0] ^ (a[15:8] * 8'd7) ^ 8'h3C;
    end

    reset = 1'b1;
    start = 1'b0;
    targetObj = 1'b0;
    startIndex = 6'd0;
    srcAddr = 16'h0000;
    count = 7'd0;
    busGnt = 1'b1;
    rdData = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during the second read: only the spec write and first data write may appear.
    expQ.push_back('{addr: 16'hFF68, data: 8'h87});
    expQ.push_back('{addr: 16'hFF69, data: mem[16'h3000]});
    @(posedge clk);
    #1;
    start = 1'b1;
    targetObj = 1'b0;
    startIndex = 6'h07;
    srcAddr = 16'h3000;
    count = 7'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("abort_rd_en", 32'(rdEn), 32'd1);
    checkOutput("abort_rd_addr", 32'(rdAddr), 32'h3001);
    checkOutput("abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    checkResetOutputs("abort");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    doneSeen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) doneSeen = 1;
    end
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
    checkOutput("abort_pending_writes", 32'(expQ.size()), 32'd0);
    expQ.delete();

`ifdef PALLOAD_CHECKSUM_EN
    mem[16'hD000] = 8'h01;
    mem[16'hD001] = 8'hFF;
    mem[16'hD002] = 8'h80;
    v = '{1'b0, 6'h00, 16'hD000, 7'd3, 0, 0, 0, 9};
    applyStimulus(v, "csum");
    checkOutput("csum_const", 32'(checksum), 32'h80);
`else
    v = '{1'b1, 6'h20, 16'hD000, 7'd1, 0, 0, 0, 5};
    applyStimulus(v, "single");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
